mem_arbiter: RTL and testbench

Sequencing and arbitration controller that sits in front of the single-ported data memory of the 5-stage pipeline. It shares the memory between the pipeline MEM stage and a loader/DMA port. It registers each granted access, holds the memory signals stable for a programmable number of wait cycles, and returns read data. The pipeline sees the block through a stall signal; the loader sees it through a req/ack handshake.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - pipeline, loader and memory signals of the data-memory arbiter
interface mem_arbiter_if;
    logic        p_memread;
    logic        p_memwrite;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [31:0] p_rdata;
    logic        p_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_rdata;
    logic        busy;

    // Requesters and the memory model sit on the master side.
    modport master (
        output p_memread, p_memwrite, p_addr, p_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output m_rdata,
        input  p_rdata, p_stall, d_rdata, d_ack,
        input  m_addr, m_wdata, m_read, m_write, busy
    );

    modport slave (
        input  p_memread, p_memwrite, p_addr, p_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_rdata,
        output p_rdata, p_stall, d_rdata, d_ack,
        output m_addr, m_wdata, m_read, m_write, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one data memory between pipeline and loader
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int WAIT   = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic       GNT_PIPE = 1'b0;
    localparam logic       GNT_LOAD = 1'b1;
    localparam logic [3:0] WAIT_L   = 4'(WAIT);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic        we_q, we_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] p_rdata_q, p_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        m_read_q, m_read_d;
    logic        m_write_q, m_write_d;
    logic        d_ack_q, d_ack_d;
    logic        preq;
    logic        pick_load;
    logic [31:0] rd_value;

    function automatic logic in_range(input logic [31:0] a);
        return (a >> ADDR_W) == 32'd0;
    endfunction

    assign preq = bus.p_memread | bus.p_memwrite;

    // Under contention the requester not served last wins.
    always_comb begin
        if (preq && bus.d_req) pick_load = (last_grant_q == GNT_PIPE);
        else                   pick_load = bus.d_req;
    end

    // Out-of-range accesses never raise m_read, so they read back as zero.
    assign rd_value = m_read_q ? bus.m_rdata : 32'd0;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        p_rdata_d    = p_rdata_q;
        d_rdata_d    = d_rdata_q;
        m_read_d     = 1'b0;
        m_write_d    = 1'b0;
        d_ack_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (preq || bus.d_req) begin
                    grant_d   = pick_load;
                    we_d      = pick_load ? bus.d_we    : bus.p_memwrite;
                    m_addr_d  = pick_load ? bus.d_addr  : bus.p_addr;
                    m_wdata_d = pick_load ? bus.d_wdata : bus.p_wdata;
                    cnt_d     = 4'd0;
                    m_write_d = we_d && in_range(m_addr_d);
                    m_read_d  = !we_d && in_range(m_addr_d);
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == WAIT_L) begin
                    if (!we_q) begin
                        if (grant_q == GNT_LOAD) d_rdata_d = rd_value;
                        else                     p_rdata_d = rd_value;
                    end
                    d_ack_d = (grant_q == GNT_LOAD);
                    state_d = DONE;
                end else begin
                    m_read_d  = m_read_q;
                    m_write_d = m_write_q;
                    cnt_d     = cnt_q + 4'd1;
                end
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= GNT_PIPE;
            last_grant_q <= GNT_LOAD;
            we_q         <= 1'b0;
            cnt_q        <= 4'd0;
            m_addr_q     <= 32'd0;
            m_wdata_q    <= 32'd0;
            p_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
            m_read_q     <= 1'b0;
            m_write_q    <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            cnt_q        <= cnt_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            p_rdata_q    <= p_rdata_d;
            d_rdata_q    <= d_rdata_d;
            m_read_q     <= m_read_d;
            m_write_q    <= m_write_d;
            d_ack_q      <= d_ack_d;
        end
    end

    // The pipeline is released only in the DONE cycle of its own access.
    assign bus.p_stall = preq & ~((state_q == DONE) && (grant_q == GNT_PIPE));
    assign bus.busy    = (state_q != IDLE);
    assign bus.p_rdata = p_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_read  = m_read_q;
    assign bus.m_write = m_write_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;
    localparam int W      = 1;
    localparam bit PIPE   = 1'b0;
    localparam bit LOADER = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;

    mem_arbiter_if bus ();
    mem_arbiter_if bw0 ();
    mem_arbiter_if bw15 ();

    mem_arbiter #(.ADDR_W(6), .WAIT(W))  u_dut (.clk(clk), .rst(rst), .bus(bus.slave));
    mem_arbiter #(.ADDR_W(6), .WAIT(0))  u_w0  (.clk(clk), .rst(rst), .bus(bw0.slave));
    mem_arbiter #(.ADDR_W(6), .WAIT(15)) u_w15 (.clk(clk), .rst(rst), .bus(bw15.slave));

    always #5 clk = ~clk;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic [31:0] exp_prdata = 32'd0;
    logic [31:0] exp_drdata = 32'd0;
    bit          last_grant = LOADER;
    int          passed = 0;
    int          total = 0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'(i * 12);
        end else if (bus.m_write) begin
            mem[bus.m_addr[5:0]] <= bus.m_wdata;
        end
    end

    assign bus.m_rdata  = mem[bus.m_addr[5:0]];
    assign bw0.m_rdata  = 32'd0;
    assign bw15.m_rdata = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] model_access(input bit we, input logic [31:0] a,
                                                 input logic [31:0] d, input logic [31:0] old);
        if (a >= 32'd64) return we ? old : 32'd0;
        if (we) begin
            ref_mem[a[5:0]] = d;
            return old;
        end
        return ref_mem[a[5:0]];
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h8000_0000 | 32'($urandom_range(0, 63));
        if (r == 1) return 32'($urandom_range(64, 70));
        return 32'($urandom_range(0, 15));
    endfunction

    // One group of requests raised together in IDLE, checked cycle by cycle until all complete.
    task automatic do_batch(input bit use_p, input bit p_we, input logic [31:0] pa, input logic [31:0] pd,
                            input bit use_d, input bit dwe, input logic [31:0] da, input logic [31:0] dd);
        bit p_first, p_in, d_in, win_p, win_d;
        int p_lo, d_lo, p_done, d_done, last_done;
        logic [31:0] p_new, d_new;
        p_in    = (pa < 32'd64);
        d_in    = (da < 32'd64);
        p_first = use_p && (!use_d || last_grant == LOADER);
        p_lo    = p_first ? 1 : W + 4;
        d_lo    = p_first ? W + 4 : 1;
        p_done  = p_lo + W + 1;
        d_done  = d_lo + W + 1;
        last_done = (use_p && use_d) ? 2 * W + 5 : W + 2;
        p_new = exp_prdata;
        d_new = exp_drdata;
        if (p_first) begin
            if (use_p) p_new = model_access(p_we, pa, pd, p_new);
            if (use_d) d_new = model_access(dwe, da, dd, d_new);
        end else begin
            if (use_d) d_new = model_access(dwe, da, dd, d_new);
            if (use_p) p_new = model_access(p_we, pa, pd, p_new);
        end
        for (int c = 0; c <= last_done; c++) begin
            @(negedge clk);
            bus.p_memread  = use_p && !p_we && c <= p_done;
            bus.p_memwrite = use_p && p_we && c <= p_done;
            bus.p_addr     = pa;
            bus.p_wdata    = pd;
            bus.d_req      = use_d && c <= d_done;
            bus.d_we       = dwe;
            bus.d_addr     = da;
            bus.d_wdata    = dd;
            #1;
            win_p = use_p && c >= p_lo && c <= p_lo + W;
            win_d = use_d && c >= d_lo && c <= d_lo + W;
            chk("p_stall", 32'(bus.p_stall), 32'(use_p && c < p_done));
            chk("d_ack", 32'(bus.d_ack), 32'(use_d && c == d_done));
            chk("busy", 32'(bus.busy), 32'(c != 0 && !(use_p && use_d && c == W + 3)));
            chk("m_read", 32'(bus.m_read), 32'((win_p && !p_we && p_in) || (win_d && !dwe && d_in)));
            chk("m_write", 32'(bus.m_write), 32'((win_p && p_we && p_in) || (win_d && dwe && d_in)));
            if (win_p) chk("m_addr_p", bus.m_addr, pa);
            if (win_d) chk("m_addr_d", bus.m_addr, da);
            if (win_p && p_we) chk("m_wdata_p", bus.m_wdata, pd);
            if (win_d && dwe) chk("m_wdata_d", bus.m_wdata, dd);
            if (c == p_done) exp_prdata = p_new;
            if (c == d_done) exp_drdata = d_new;
            chk("p_rdata", bus.p_rdata, exp_prdata);
            chk("d_rdata", bus.d_rdata, exp_drdata);
        end
        if (use_p && use_d) last_grant = p_first ? LOADER : PIPE;
        else                last_grant = use_p ? PIPE : LOADER;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pu, du, pw, dw;
        logic [31:0] pa, pd, da, dd;
        int kind, n0, n15;
        bit done0, done15;

        for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i * 12);
        bus.p_memread = 0; bus.p_memwrite = 0; bus.p_addr = 0; bus.p_wdata = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        bw0.p_memread = 0; bw0.p_memwrite = 0; bw0.p_addr = 0; bw0.p_wdata = 0;
        bw0.d_req = 0; bw0.d_we = 0; bw0.d_addr = 0; bw0.d_wdata = 0;
        bw15.p_memread = 0; bw15.p_memwrite = 0; bw15.p_addr = 0; bw15.p_wdata = 0;
        bw15.d_req = 0; bw15.d_we = 0; bw15.d_addr = 0; bw15.d_wdata = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_d_ack", 32'(bus.d_ack), 32'd0);
        chk("rst_m_read", 32'(bus.m_read), 32'd0);
        chk("rst_m_write", 32'(bus.m_write), 32'd0);
        chk("rst_m_addr", bus.m_addr, 32'd0);
        chk("rst_p_rdata", bus.p_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        chk("rst_p_stall", 32'(bus.p_stall), 32'd0);
        preload = 0;
        rst = 0;

        // first contention goes to the pipeline, then directed scenarios
        do_batch(1, 0, 32'd0, 32'd0, 1, 1, 32'd1, 32'd7);
        do_batch(1, 1, 32'd3, 32'hDEADBEEF, 0, 0, 32'd0, 32'd0);
        do_batch(1, 0, 32'd3, 32'd0, 0, 0, 32'd0, 32'd0);
        do_batch(0, 0, 32'd0, 32'd0, 1, 0, 32'd5, 32'd0);
        do_batch(1, 0, 32'd64, 32'd0, 0, 0, 32'd0, 32'd0);
        do_batch(1, 0, 32'd1, 32'd0, 1, 0, 32'd0, 32'd0);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            pu = (kind != 1);
            du = (kind != 0);
            pw = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            pa = rand_addr();
            da = rand_addr();
            pd = $urandom;
            dd = $urandom;
            do_batch(pu, pw, pa, pd, du, dw, da, dd);
        end

        // reset during the second ACCESS cycle of a loader write
        @(negedge clk);
        bus.p_memread = 0; bus.p_memwrite = 0;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'd9; bus.d_wdata = 32'hA5A5_0009;
        @(negedge clk); #1;
        chk("mid_rst_acc1_m_write", 32'(bus.m_write), 32'd1);
        @(negedge clk);
        rst = 1; bus.d_req = 0;
        #1;
        chk("mid_rst_acc2_m_write", 32'(bus.m_write), 32'd1);
        @(negedge clk);
        bus.p_memread = 1; bus.p_addr = 32'd2;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_d_ack", 32'(bus.d_ack), 32'd0);
        chk("mid_rst_m_read", 32'(bus.m_read), 32'd0);
        chk("mid_rst_m_write", 32'(bus.m_write), 32'd0);
        chk("mid_rst_m_addr", bus.m_addr, 32'd0);
        chk("mid_rst_m_wdata", bus.m_wdata, 32'd0);
        chk("mid_rst_p_rdata", bus.p_rdata, 32'd0);
        chk("mid_rst_d_rdata", bus.d_rdata, 32'd0);
        chk("mid_rst_p_stall", 32'(bus.p_stall), 32'd1);
        @(negedge clk);
        rst = 0; bus.p_memread = 0;
        #1;
        chk("post_rst_d_ack", 32'(bus.d_ack), 32'd0);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        ref_mem[9] = 32'hA5A5_0009;
        exp_prdata = 32'd0;
        exp_drdata = 32'd0;
        last_grant = LOADER;
        do_batch(1, 0, 32'd9, 32'd0, 1, 0, 32'd9, 32'd0);

        // stall length of an uncontended load for WAIT=0 and WAIT=15
        n0 = 0; n15 = 0; done0 = 0; done15 = 0;
        @(negedge clk);
        bw0.p_memread = 1;
        bw15.p_memread = 1;
        for (int c = 0; c < 40 && !(done0 && done15); c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (!done0) begin
                if (bw0.p_stall) n0++;
                else begin done0 = 1; bw0.p_memread = 0; end
            end
            if (!done15) begin
                if (bw15.p_stall) n15++;
                else begin done15 = 1; bw15.p_memread = 0; end
            end
        end
        chk("w0_completed", 32'(done0), 32'd1);
        chk("w15_completed", 32'(done15), 32'd1);
        chk("w0_stall_len", 32'(n0), 32'd2);
        chk("w15_stall_len", 32'(n15), 32'd17);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
